// File: rtl/mem_sram_bridge_if.sv
// Native minrv32 memory-port handshake between the core (master) and a memory stage (slave).
interface mem_sram_bridge_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata, mem_err
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata, mem_err
   );
endinterface

// File: rtl/mem_sram_bridge.sv
// Single-outstanding bridge from the minrv32 memory port onto a synchronous byte-lane SRAM,
// with programmable wait states, error completion for illegal requests and a debug error counter.
module mem_sram_bridge #(
   parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
   parameter int          MEM_WORDS   = 4096,
   localparam int         AW          = $clog2(MEM_WORDS),
   parameter int          WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              resetn,
   mem_sram_bridge_if.slave  mem,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [AW-1:0]     sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic [7:0]        err_count
);

   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP, S_ERR} state_t;

   localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);
   localparam logic [3:0]  WS        = 4'(WAIT_STATES);

   state_t      state, state_nx;
   logic [31:0] off;
   logic        req_err;
   logic [3:0]  wstrb_q;
   logic [3:0]  wcnt;
   logic [31:0] rdata_q;
   logic [31:0] rdata_r;
   logic        ready_r;
   logic        err_r;
   logic        first_wait;

   // Unsigned offset: addresses below the window wrap to huge values and fail the range test.
   assign off     = mem.mem_addr - ADDR_BASE;
   assign req_err = (off >= WIN_BYTES) || (mem.mem_addr[1:0] != 2'b00) ||
                    (mem.mem_instr && (mem.mem_wstrb != 4'h0));

   assign first_wait = (state == S_WAIT) && (wcnt == WS);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (mem.mem_valid) state_nx = req_err ? S_ERR : S_ACCESS;
         S_ACCESS: state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
         S_WAIT:   if (wcnt <= 4'd1) state_nx = S_RESP;
         S_RESP:   state_nx = S_IDLE;
         S_ERR:    state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         sram_en    <= 1'b0;
         sram_we    <= 4'h0;
         sram_addr  <= '0;
         sram_wdata <= 32'h0;
         wstrb_q    <= 4'h0;
         wcnt       <= 4'h0;
         rdata_q    <= 32'h0;
         rdata_r    <= 32'h0;
         ready_r    <= 1'b0;
         err_r      <= 1'b0;
         err_count  <= 8'h00;
      end else begin
         state   <= state_nx;
         sram_en <= (state_nx == S_ACCESS);
         sram_we <= (state_nx == S_ACCESS) ? mem.mem_wstrb : 4'h0;
         ready_r <= (state_nx == S_RESP) || (state_nx == S_ERR);
         err_r   <= (state_nx == S_ERR);

         if (state == S_IDLE && mem.mem_valid) wstrb_q <= mem.mem_wstrb;
         if (state_nx == S_ACCESS) begin
            sram_addr  <= off[AW+1:2];
            sram_wdata <= mem.mem_wdata;
         end

         if (state == S_ACCESS)    wcnt <= WS;
         else if (state == S_WAIT) wcnt <= wcnt - 4'd1;

         if (first_wait) rdata_q <= sram_rdata;

         // The last WAIT cycle may also be the capture cycle, so forward the SRAM word directly.
         if ((WAIT_STATES > 0) && (state_nx == S_RESP) && (wstrb_q == 4'h0))
            rdata_r <= first_wait ? sram_rdata : rdata_q;
         else
            rdata_r <= 32'h0;

         if (state_nx == S_ERR && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

   assign mem.mem_ready = ready_r;
   assign mem.mem_err   = err_r;
   // With no wait states the SRAM word only exists during RESP, so it bypasses the register.
   assign mem.mem_rdata = ((WAIT_STATES == 0) && (state == S_RESP) && (wstrb_q == 4'h0)) ?
                          sram_rdata : rdata_r;

endmodule
